// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the unified-memory SRAM data port between the
// load/store unit (LSU) and the debug loader (DBG). Sub-word stores are done
// as read-modify-write of the containing word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | arbitrate and capture the winning request
// ACCESS   | drive sram_addr; load result, word write, or merge capture
// MERGE_WR | write the merged word back for byte/half stores
// DONE     | pulse the owner's done with rdata/err
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_size,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        lsu_gnt,
  output logic        dbg_gnt,
  output logic        lsu_done,
  output logic        dbg_done,
  output logic [31:0] lsu_rdata,
  output logic [31:0] dbg_rdata,
  output logic        lsu_err,
  output logic        dbg_err,
  output logic [31:0] sram_addr,
  output logic [31:0] w_sram,
  output logic        w_sram_en,
  input  logic [31:0] r_sram
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merge_q;
  logic          lsu_err_q, dbg_err_q;
  logic [CW-1:0] starve_cnt;

  logic          any_req, pick_dbg, sel_we, sel_illegal;
  logic [1:0]    sel_size;
  logic [31:0]   sel_addr, sel_wdata;
  logic [31:0]   load_val, merge_val;
  logic          fin, fin_owner, fin_err;
  logic [31:0]   fin_rdata;

  // DBG wins when it is alone or when the LSU has starved it long enough.
  assign any_req   = lsu_req | dbg_req;
  assign pick_dbg  = dbg_req & (~lsu_req | (starve_cnt == CW'(STARVE_LIMIT)));
  assign sel_we    = pick_dbg ? dbg_we    : lsu_we;
  assign sel_size  = pick_dbg ? dbg_size  : lsu_size;
  assign sel_addr  = pick_dbg ? dbg_addr  : lsu_addr;
  assign sel_wdata = pick_dbg ? dbg_wdata : lsu_wdata;
  assign sel_illegal = (sel_size == 2'b11) |
                       ((sel_size == 2'b01) & sel_addr[0]) |
                       ((sel_size == 2'b10) & (|sel_addr[1:0]));

  assign lsu_done = (state == DONE) & ~owner_q;
  assign dbg_done = (state == DONE) &  owner_q;
  assign lsu_err  = lsu_done & lsu_err_q;
  assign dbg_err  = dbg_done & dbg_err_q;

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    load_val  = '0;
    merge_val = r_sram;
    case (size_q)
      2'b00: begin
        load_val[7:0] = r_sram[{addr_q[1:0], 3'b000} +: 8];
        merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val[15:0] = r_sram[{addr_q[1], 4'b0000} +: 16];
        merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: load_val = r_sram;
    endcase
  end

  // Completion result: written into the owner's rdata/err on entry to DONE.
  always_comb begin
    fin       = 1'b0;
    fin_owner = owner_q;
    fin_err   = 1'b0;
    fin_rdata = '0;
    case (state)
      IDLE: begin
        fin       = any_req & sel_illegal;
        fin_owner = pick_dbg;
        fin_err   = 1'b1;
      end
      ACCESS: begin
        fin       = ~we_q | (size_q == 2'b10);
        fin_rdata = we_q ? 32'h0 : load_val;
      end
      MERGE_WR: fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and SRAM port drive; writes are blocked while rst is high.
  always_comb begin
    state_nxt = state;
    sram_addr = '0;
    w_sram    = '0;
    w_sram_en = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = sel_illegal ? DONE : ACCESS;
      ACCESS: begin
        sram_addr = {addr_q[31:2], 2'b00};
        if (we_q && size_q != 2'b10) begin
          state_nxt = MERGE_WR;
        end else begin
          state_nxt = DONE;
          if (we_q) begin
            w_sram    = wdata_q;
            w_sram_en = ~rst;
          end
        end
      end
      MERGE_WR: begin
        sram_addr = {addr_q[31:2], 2'b00};
        w_sram    = merge_q;
        w_sram_en = ~rst;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, grant pulses, merge word, results and starvation count.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      lsu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      lsu_rdata  <= '0;
      dbg_rdata  <= '0;
      lsu_err_q  <= 1'b0;
      dbg_err_q  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      lsu_gnt <= 1'b0;
      dbg_gnt <= 1'b0;
      if (state == IDLE && any_req) begin
        owner_q <= pick_dbg;
        we_q    <= sel_we;
        size_q  <= sel_size;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        lsu_gnt <= ~pick_dbg;
        dbg_gnt <= pick_dbg;
      end
      if (state == ACCESS) merge_q <= merge_val;
      if (fin) begin
        if (fin_owner) begin
          dbg_rdata <= fin_rdata;
          dbg_err_q <= fin_err;
        end else begin
          lsu_rdata <= fin_rdata;
          lsu_err_q <= fin_err;
        end
      end
      if (!dbg_req)
        starve_cnt <= '0;
      else if (state == IDLE && any_req)
        starve_cnt <= pick_dbg ? '0 : starve_cnt + CW'(1);
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM data port of the unified memory (byte-addressed, little-endian, combinational word read, one 32-bit write per clock) between two requesters: the core load/store unit (LSU) and the debug/program loader (DBG). It arbitrates, sequences each access through a small state machine, and turns byte and halfword stores into a read-modify-write of the containing word. The block sits between the requesters and the memory's `sram_addr`/`w_sram`/`w_sram_en`/`r_sram` pins. The code-fetch port is not touched.

## Interface
- `STARVE_LIMIT`, default 4: consecutive LSU grants while `dbg_req` is held, after which DBG wins the next arbitration.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lsu_req`, `dbg_req`  in  1  access request; held stable with its fields until the matching `*_done`.
- `lsu_we`, `dbg_we`  in  1  1 = store, 0 = load.
- `lsu_size`, `dbg_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `lsu_addr`, `dbg_addr`  in  32  byte address, relative to the SRAM base.
- `lsu_wdata`, `dbg_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `lsu_gnt`, `dbg_gnt`  out  1  one-cycle pulse; the request has been captured.
- `lsu_done`, `dbg_done`  out  1  one-cycle pulse; the access has completed.
- `lsu_rdata`, `dbg_rdata`  out  32  load result, zero-extended; valid while `*_done` is high and held until the next done.
- `lsu_err`, `dbg_err`  out  1  valid with `*_done`: misaligned access or illegal size.
- `sram_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `w_sram`  out  32  write data to memory.
- `w_sram_en`  out  1  memory write enable.
- `r_sram`  in  32  combinational read data from memory.

## Operation
- States: IDLE, ACCESS, MERGE_WR, DONE.
- **IDLE**
  - Arbitrate among the requests that are high this cycle.
  - A winner's addr/size/we/wdata are captured, along with its owner ID.
  - Next state is ACCESS, or DONE with the error flag set if the access is illegal.
- **Arbitration**
  - LSU has fixed priority.
  - `starve_cnt` increments when LSU is granted while `dbg_req` is high. It clears when DBG is granted or when `dbg_req` is low.
  - When `starve_cnt == STARVE_LIMIT` and both requesters are high, DBG wins.
- **Illegal access**: size 11, half with `addr[0]=1`, or word with `addr[1:0]!=0`. No memory access is made; `rdata` = 0 and `err` = 1.
- **ACCESS** (drives `sram_addr`)
  - Load: byte = `r_sram[8*addr[1:0] +: 8]`, half = `r_sram[16*addr[1] +: 16]`, word = `r_sram`. The result is zero-extended, registered, and the next state is DONE.
  - Word store: `w_sram_en` = 1, `w_sram` = wdata, next state is DONE.
  - Byte/half store: register the `r_sram` word with the addressed lane(s) replaced by wdata, next state is MERGE_WR.
- **MERGE_WR**: `w_sram_en` = 1, `w_sram` = merged word, same `sram_addr`, next state is DONE.
- **DONE**: the owner's `done` pulses with `rdata`/`err`, next state is IDLE. `req` seen in DONE is ignored; if `req` is still high in the following IDLE, it is a new transaction.
- Outside ACCESS/MERGE_WR: `w_sram_en` = 0, `w_sram` = 0, `sram_addr` = 0.
- `w_sram_en` is gated by `!rst`, so no memory write occurs on any edge where `rst` is high.

## Timing
- Reset: state IDLE, `starve_cnt` 0, and every output 0 (gnt, done, err, rdata, `sram_addr`, `w_sram`, `w_sram_en`).
- Counting cycle 0 as the IDLE cycle in which the request is sampled:
  - `gnt` is high in cycle 1.
  - Load, word store and error: `done` in cycle 2 (errors go IDLE→DONE, `done` in cycle 1 with `gnt` in the same cycle).
  - Byte/half store: `done` in cycle 3.
- Throughput: a new request can be sampled in the cycle after DONE. A word load therefore repeats every 3 cycles.
- The non-granted requester waits with `req` held; its `gnt` stays 0.
- Reset in ACCESS or MERGE_WR aborts the transaction: no write, no done, and the requester must re-issue after reset.
- Only one `*_gnt` and one `*_done` can be high in any cycle.

## Test plan
- Reset, then LSU word store of 0xDEADBEEF at 0x10 → `w_sram_en` high for exactly one cycle (cycle 1), `sram_addr` = 0x10, `lsu_done` in cycle 2; a following load of 0x10 returns 0xDEADBEEF.
- Byte stores of 0x5A at 0x12 and half store of 0x1234 at 0x10, on top of word 0xDEADBEEF → final word 0xDE5A1234, each store has `done` in cycle 3, and `w_sram_en` is high only in MERGE_WR.
- Loads of byte at 0x13 and half at 0x12 from word 0xDE5A1234 → `rdata` = 0x000000DE and 0x0000DE5A.
- Half load at 0x11, word store at 0x12, and size 11 → `err` = 1, `rdata` = 0, `w_sram_en` never asserted, memory word unchanged.
- `lsu_req` and `dbg_req` held continuously with `STARVE_LIMIT` = 4 → grant order LSU, LSU, LSU, LSU, DBG, LSU…; with `dbg_req` alone → DBG is granted immediately.
- `rst` asserted in the MERGE_WR cycle of a byte store → no memory write, no `done`, all outputs 0 on the next cycle, and the target word is unchanged.
